arith_pipe_datapath: RTL and testbench
======================================

ARITH_PIPE_DATAPATH -- requirements
Module: arith_pipe_datapath

Interface
REQ-001 Parameter N, default 16, operand/result width in bits (legal 4..32).
REQ-002 Parameter PIPE, default 2, number of output register stages (legal 0..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand set A/B/opcode valid this cycle.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 A  input  N  signed operand A.
REQ-008 B  input  N  signed operand B.
REQ-009 opcode  input  3  operation select.
REQ-010 out_valid  output  1  Y/co valid.
REQ-011 out_ready  input  1  downstream accepts Y/co this cycle.
REQ-012 Y  output  N  signed result.
REQ-013 co  output  1  carry/borrow/saturation flag.

Function
REQ-014 Transfer occurs on a rising edge where valid and ready are both high; in-transfer = in_valid && in_ready, out-transfer = out_valid && out_ready.
REQ-015 Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SADD, 110 MAC, 111 CLRACC.
REQ-016 ADD: Y = (A+B) mod 2^N; co = unsigned carry out of bit N-1.
REQ-017 SUB: Y = (A-B) mod 2^N; co = unsigned borrow (1 when A < B unsigned).
REQ-018 AND/OR/XOR: bitwise result; co = 0.
REQ-019 SADD: signed add clamped to [-2^(N-1), 2^(N-1)-1]; co = 1 only when clamped.
REQ-020 MAC: internal N-bit signed accumulator acc; acc_next = sat(acc + trunc_2N(A*B)) clamped to N-bit signed range; Y = acc_next; co = 1 when clamped.
REQ-021 CLRACC: acc_next = 0; Y = previous acc value; co = 0.
REQ-022 acc updates only on an in-transfer with opcode MAC or CLRACC; otherwise holds.
REQ-023 Back-to-back MAC/CLRACC in consecutive accepted cycles see the acc written by the prior accepted operation (no hazard at any PIPE).
REQ-024 Result computed combinationally from accepted operands, then carried through PIPE register stages, each with a valid bit.
REQ-025 PIPE = 0: out_valid = in_valid, in_ready = out_ready, Y/co combinational from inputs, latency 0.
REQ-026 PIPE >= 1: global advance enable en = !out_valid || out_ready; in_ready = en; all stages shift on en; latency exactly PIPE cycles with no stall.
REQ-027 When en = 0 all stage registers, valid bits and acc hold; no result lost or duplicated.
REQ-028 Stage valid bit loads in-transfer on en; a cycle with in_valid = 0 injects a bubble.
REQ-029 Results emerge in acceptance order.
REQ-030 Y/co hold stable while out_valid && !out_ready.
REQ-031 Opcode/operand values with in_valid = 0 have no effect on acc or outputs.

Reset
REQ-032 On rising edge with rst = 1: all stage valid bits = 0, stage data = 0, acc = 0; thereafter out_valid = 0, Y = 0, co = 0.
REQ-033 rst has priority over in-transfer and stall; in-flight results are discarded.
REQ-034 in_ready = 1 in the first cycle after reset release (PIPE >= 1).

Structure
REQ-035 Package arith_pipe_pkg holds opcode enum (OP_ADD..OP_CLRACC) and width-3 opcode typedef.
REQ-036 Sub-module arith_alu (combinational, parameter N): A, B, opcode, acc -> result, co, acc_next.
REQ-037 Pipeline stages generated by generate loop over PIPE; acc register lives in arith_pipe_datapath.

Verification (N=16, PIPE=2 unless stated)
REQ-038 ADD 16'hFFFF+16'h0001 -> 2 cycles later Y=16'h0000 co=1; ADD 16'h7FFF+1 -> Y=16'h8000 co=0.
REQ-039 SADD 32767+1 -> Y=32767 co=1; SADD -32768+(-1) -> Y=-32768 co=1; SADD 5+(-3) -> Y=2 co=0.
REQ-040 CLRACC, MAC(3,4), MAC(-2,5) back-to-back -> Y=old acc, 12, 2; co=0 each.
REQ-041 Four consecutive ADDs, out_ready low 3 cycles from first out_valid -> in_ready low during stall, Y/co stable, all four results delivered in order once, none dropped.
REQ-042 rst pulsed with 2 results in flight and acc=12 -> next cycle out_valid=0 Y=0 co=0; then MAC(1,1) -> Y=1.
REQ-043 PIPE=0 instance: SUB 3-5 -> same cycle Y=-2 co=1, out_valid follows in_valid, in_ready follows out_ready.

Source files
------------

// File: rtl/arith_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arith_pipe_pkg : opcode encoding shared by the datapath and its ALU  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arith_pipe_pkg;

  localparam int OPCODE_W = 3;

  typedef logic [OPCODE_W-1:0] opcode_t;

  typedef enum opcode_t {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_AND    = 3'b010,
    OP_OR     = 3'b011,
    OP_XOR    = 3'b100,
    OP_SADD   = 3'b101,
    OP_MAC    = 3'b110,
    OP_CLRACC = 3'b111
  } op_e;

  // Opcodes that write the accumulator when accepted.
  function automatic logic is_acc_op(input opcode_t op);
    return (op == OP_MAC) || (op == OP_CLRACC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arith_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arith_alu : combinational ALU with saturating add and MAC            |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arith_alu
  import arith_pipe_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  opcode_t      opcode,
  input  logic [N-1:0] acc,
  output logic [N-1:0] result,
  output logic         co,
  output logic [N-1:0] acc_next
);

  localparam logic signed [2*N:0] MAX_W = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] MIN_W = {{(N+2){1'b1}}, {(N-1){1'b0}}};
  localparam logic [N-1:0]        MAX_N = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]        MIN_N = {1'b1, {(N-1){1'b0}}};

  // Returns {clamped, value} for a wide signed sum squeezed into N bits.
  function automatic logic [N:0] sat(input logic signed [2*N:0] v);
    if (v > MAX_W) begin
      return {1'b1, MAX_N};
    end else if (v < MIN_W) begin
      return {1'b1, MIN_N};
    end
    return {1'b0, v[N-1:0]};
  endfunction

  logic [N:0]               sum_u;
  logic [N:0]               diff_u;
  logic signed [2*N-1:0]    a_x2;
  logic signed [2*N-1:0]    b_x2;
  logic signed [2*N-1:0]    prod;
  logic signed [2*N:0]      a_w;
  logic signed [2*N:0]      b_w;
  logic signed [2*N:0]      acc_w;
  logic signed [2*N:0]      sadd_w;
  logic signed [2*N:0]      mac_w;
  logic [N:0]               sadd_s;
  logic [N:0]               mac_s;

  always_comb begin
    sum_u  = {1'b0, a} + {1'b0, b};
    diff_u = {1'b0, a} - {1'b0, b};
    a_x2   = {{N{a[N-1]}}, a};
    b_x2   = {{N{b[N-1]}}, b};
    prod   = a_x2 * b_x2;
    a_w    = {{(N+1){a[N-1]}}, a};
    b_w    = {{(N+1){b[N-1]}}, b};
    acc_w  = {{(N+1){acc[N-1]}}, acc};
    sadd_w = a_w + b_w;
    mac_w  = acc_w + {prod[2*N-1], prod};
    sadd_s = sat(sadd_w);
    mac_s  = sat(mac_w);

    result   = '0;
    co       = 1'b0;
    acc_next = acc;
    case (opcode)
      OP_ADD:    {co, result} = sum_u;
      OP_SUB: begin
        result = diff_u[N-1:0];
        co     = diff_u[N];
      end
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_SADD:   {co, result} = sadd_s;
      OP_MAC: begin
        {co, acc_next} = mac_s;
        result         = mac_s[N-1:0];
      end
      OP_CLRACC: begin
        result   = acc;
        acc_next = '0;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/arith_pipe_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arith_pipe_datapath : valid/ready ALU with PIPE output stages        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arith_pipe_datapath
  import arith_pipe_pkg::*;
#(
  parameter int N    = 16,
  parameter int PIPE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  opcode_t      opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic         co
);

  logic [N-1:0] alu_result;
  logic [N-1:0] alu_acc_next;
  logic         alu_co;
  logic [N-1:0] acc_q;
  logic [N-1:0] acc_d;
  logic         in_xfer;

  arith_alu #(.N(N)) u_alu (
    .a        (A),
    .b        (B),
    .opcode   (opcode),
    .acc      (acc_q),
    .result   (alu_result),
    .co       (alu_co),
    .acc_next (alu_acc_next)
  );

  assign in_xfer = in_valid && in_ready;

  // The accumulator commits at acceptance, so the next accepted op sees it.
  always_comb begin
    acc_d = acc_q;
    if (in_xfer && is_acc_op(opcode)) begin
      acc_d = alu_acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  generate
    if (PIPE == 0) begin : g_comb
      assign in_ready  = out_ready;
      assign out_valid = in_valid;
      assign Y         = alu_result;
      assign co        = alu_co;
    end else begin : g_pipe
      logic                  en;
      logic [PIPE:0]         vld_c;
      logic [PIPE:0][N-1:0]  y_c;
      logic [PIPE:0]         co_c;

      assign en       = !vld_c[PIPE] || out_ready;
      assign vld_c[0] = in_valid;
      // Bubbles carry zero data so an idle output reads as zero.
      assign y_c[0]   = in_valid ? alu_result : '0;
      assign co_c[0]  = in_valid && alu_co;

      for (genvar s = 0; s < PIPE; s++) begin : g_stage
        logic         vld_q;
        logic         vld_d;
        logic [N-1:0] y_q;
        logic [N-1:0] y_d;
        logic         co_q;
        logic         co_d;

        always_comb begin
          vld_d = vld_q;
          y_d   = y_q;
          co_d  = co_q;
          if (en) begin
            vld_d = vld_c[s];
            y_d   = y_c[s];
            co_d  = co_c[s];
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            vld_q <= 1'b0;
            y_q   <= '0;
            co_q  <= 1'b0;
          end else begin
            vld_q <= vld_d;
            y_q   <= y_d;
            co_q  <= co_d;
          end
        end

        assign vld_c[s+1] = vld_q;
        assign y_c[s+1]   = y_q;
        assign co_c[s+1]  = co_q;
      end

      assign in_ready  = en;
      assign out_valid = vld_c[PIPE];
      assign Y         = y_c[PIPE];
      assign co        = co_c[PIPE];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_arith_pipe_datapath.sv
`default_nettype none
// Bench for arith_pipe_datapath: PIPE=2 instance against a queue model,
// plus a PIPE=0 instance checked with directed literals.
module tb_arith_pipe_datapath;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SADD = 3'd5;
  localparam logic [2:0] OP_MAC  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef struct {
    logic [15:0] y;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  op = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] y;
  logic        co;

  logic        p0_in_valid = 1'b0;
  logic        p0_out_ready = 1'b1;
  logic [15:0] p0_a = '0;
  logic [15:0] p0_b = '0;
  logic [2:0]  p0_op = '0;
  logic        p0_in_ready;
  logic        p0_out_valid;
  logic [15:0] p0_y;
  logic        p0_co;

  always #5 clk = ~clk;

  arith_pipe_datapath #(.N(16), .PIPE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .opcode(op), .out_valid(out_valid), .out_ready(out_ready),
    .Y(y), .co(co)
  );

  arith_pipe_datapath #(.N(16), .PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(p0_in_valid), .in_ready(p0_in_ready),
    .A(p0_a), .B(p0_b), .opcode(p0_op), .out_valid(p0_out_valid),
    .out_ready(p0_out_ready), .Y(p0_y), .co(p0_co)
  );

  int          n_pass = 0;
  int          n_total = 0;
  int          n_deliv = 0;
  longint      m_acc = 0;
  exp_t        q[$];
  logic        held_v = 1'b0;
  logic [15:0] held_y = '0;
  logic        held_c = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endtask

  task automatic sat16(input longint t, output logic [15:0] r, output logic c);
    if (t > 32767) begin
      r = 16'h7FFF; c = 1'b1;
    end else if (t < -32768) begin
      r = 16'h8000; c = 1'b1;
    end else begin
      r = t[15:0]; c = 1'b0;
    end
  endtask

  // Reference behaviour written as plain integer arithmetic.
  task automatic model_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] z,
                          output logic [15:0] r, output logic c);
    longint sx, sz, t;
    sx = longint'($signed(x));
    sz = longint'($signed(z));
    r = '0;
    c = 1'b0;
    case (o)
      OP_ADD: begin
        t = longint'(x) + longint'(z);
        r = t[15:0];
        c = (t > 65535);
      end
      OP_SUB: begin
        r = x - z;
        c = (x < z);
      end
      OP_AND: r = x & z;
      OP_OR:  r = x | z;
      OP_XOR: r = x ^ z;
      OP_SADD: sat16(sx + sz, r, c);
      OP_MAC: begin
        sat16(m_acc + sx * sz, r, c);
        m_acc = longint'($signed(r));
      end
      default: begin
        t = m_acc;
        r = t[15:0];
        m_acc = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      m_acc = 0;
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("hold_vld", 32'(out_valid), 32'(1'b1));
        chk("hold_y", 32'(y), 32'(held_y));
        chk("hold_co", 32'(co), 32'(held_c));
      end
      held_v = out_valid && !out_ready;
      held_y = y;
      held_c = co;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL sb_extra: got unexpected result %h required none", y);
        end else begin
          e = q.pop_front();
          chk("sb_y", 32'(y), 32'(e.y));
          chk("sb_co", 32'(co), 32'(e.c));
          n_deliv++;
        end
      end
      if (in_valid && in_ready) begin
        model_op(op, a, b, e.y, e.c);
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [15:0] x, input logic [15:0] z);
    op = o; a = x; b = z; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_chk(input string nm, input logic [2:0] o, input logic [15:0] x,
                          input logic [15:0] z, input logic [15:0] ey, input logic ec);
    drive(o, x, z);
    idle(1);
    chk({nm, "_vld"}, 32'(out_valid), 32'(1'b1));
    chk({nm, "_y"}, 32'(y), 32'(ey));
    chk({nm, "_co"}, 32'(co), 32'(ec));
  endtask

  logic [2:0]  mix_op [8] = '{OP_AND, OP_OR, OP_XOR, OP_SUB, OP_ADD, OP_SADD, OP_MAC, OP_MAC};
  logic [15:0] mix_a  [8] = '{16'hF0F0, 16'h1200, 16'hAAAA, 16'h0005, 16'h8000, 16'h8000, 16'h0100, 16'hFFFF};
  logic [15:0] mix_b  [8] = '{16'h3C3C, 16'h0034, 16'hFFFF, 16'h0003, 16'h8000, 16'h8000, 16'h0100, 16'h0002};
  logic [15:0] st_a   [4] = '{16'h0010, 16'h0020, 16'h0030, 16'hFFF0};
  logic [15:0] st_b   [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0020};

  initial begin
    int  idx;
    int  stall_left;
    logic stalled;
    logic took;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_y", 32'(y), 32'(16'h0000));
    chk("rst_co", 32'(co), 32'(1'b0));
    chk("rst_in_ready", 32'(in_ready), 32'(1'b1));

    send_chk("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    send_chk("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    send_chk("sadd_max", OP_SADD, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
    send_chk("sadd_min", OP_SADD, 16'h8000, 16'hFFFF, 16'h8000, 1'b1);
    send_chk("sadd_mid", OP_SADD, 16'h0005, 16'hFFFD, 16'h0002, 1'b0);
    send_chk("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b1);
    send_chk("mac_sat", OP_MAC, 16'h7FFF, 16'h0002, 16'h7FFF, 1'b1);

    // Operands presented without in_valid must leave the accumulator alone.
    op = OP_MAC; a = 16'h0100; b = 16'h0100;
    idle(1);

    drive(OP_CLR, 16'h0000, 16'h0000);
    drive(OP_MAC, 16'h0003, 16'h0004);
    chk("b2b_clr_y", 32'(y), 32'(16'h7FFF));
    chk("b2b_clr_co", 32'(co), 32'(1'b0));
    drive(OP_MAC, 16'hFFFE, 16'h0005);
    chk("b2b_mac1_y", 32'(y), 32'(16'd12));
    chk("b2b_mac1_co", 32'(co), 32'(1'b0));
    idle(1);
    chk("b2b_mac2_y", 32'(y), 32'(16'd2));
    chk("b2b_mac2_co", 32'(co), 32'(1'b0));
    idle(3);

    for (int i = 0; i < 8; i++) drive(mix_op[i], mix_a[i], mix_b[i]);
    idle(4);

    n_deliv = 0;
    idx = 0;
    stall_left = 0;
    stalled = 1'b0;
    for (int cyc = 0; cyc < 40 && n_deliv < 4; cyc++) begin
      if (out_valid && !stalled) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid = (idx < 4);
      op = OP_ADD;
      a = (idx < 4) ? st_a[idx] : 16'h0000;
      b = (idx < 4) ? st_b[idx] : 16'h0000;
      #1;
      if (stall_left > 0) chk("stall_in_ready", 32'(in_ready), 32'(1'b0));
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) idx++;
      if (stall_left > 0) stall_left--;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stall_stalled", 32'(stalled), 32'(1'b1));
    chk("stall_delivered", 32'(n_deliv), 32'(4));
    idle(3);

    drive(OP_CLR, 16'h0000, 16'h0000);
    drive(OP_MAC, 16'h0003, 16'h0004);
    drive(OP_ADD, 16'h0001, 16'h0001);
    drive(OP_ADD, 16'h0002, 16'h0002);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstf_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rstf_y", 32'(y), 32'(16'h0000));
    chk("rstf_co", 32'(co), 32'(1'b0));
    chk("rstf_in_ready", 32'(in_ready), 32'(1'b1));
    send_chk("mac_after_rst", OP_MAC, 16'h0001, 16'h0001, 16'h0001, 1'b0);
    idle(3);
    chk("sb_empty", 32'(q.size()), 32'(0));

    p0_op = OP_SUB; p0_a = 16'h0003; p0_b = 16'h0005;
    p0_in_valid = 1'b1; p0_out_ready = 1'b1;
    #1;
    chk("p0_sub_y", 32'(p0_y), 32'(16'hFFFE));
    chk("p0_sub_co", 32'(p0_co), 32'(1'b1));
    chk("p0_out_valid", 32'(p0_out_valid), 32'(1'b1));
    chk("p0_in_ready", 32'(p0_in_ready), 32'(1'b1));
    p0_out_ready = 1'b0;
    #1;
    chk("p0_in_ready_low", 32'(p0_in_ready), 32'(1'b0));
    p0_in_valid = 1'b0;
    #1;
    chk("p0_out_valid_low", 32'(p0_out_valid), 32'(1'b0));
    @(posedge clk); #1;
    p0_out_ready = 1'b1;
    p0_op = OP_MAC; p0_a = 16'h0002; p0_b = 16'h0003; p0_in_valid = 1'b1;
    @(posedge clk); #1;
    p0_op = OP_CLR;
    #1;
    chk("p0_clr_y", 32'(p0_y), 32'(16'd6));
    p0_in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
